// File: rtl/fp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : fp_pkg                                                      |
// | Brief  : shared types for the iterative floating-point divider       |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
package fp_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DIV   = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    NORMAL = 2'd1,
    INF    = 2'd2,
    NAN    = 2'd3
  } cls_e;

  typedef struct packed {
    logic invalid;
    logic dbz;
    logic overflow;
    logic underflow;
    logic inexact;
  } flags_t;

endpackage
`default_nettype wire

// File: rtl/mant_div.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : mant_div                                                    |
// | Brief  : restoring divider, q = floor(2^(N+2)*dividend/divisor)      |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module mant_div #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N+2:0] q,
  output logic [N-1:0] rem
);

  localparam int STEPS = N + 3;
  localparam int CW    = $clog2(STEPS + 1);

  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic [N:0]    r_part;
  logic [N-1:0]  r_div;
  logic [N+2:0]  r_q;

  logic          w_ge;
  logic [N-1:0]  w_diff;
  logic [N-1:0]  w_rest;

  // The partial remainder stays below 2*divisor, so N+1 bits suffice.
  assign w_ge   = r_part >= {1'b0, r_div};
  assign w_diff = r_part[N-1:0] - r_div;
  assign w_rest = w_ge ? w_diff : r_part[N-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_part <= '0;
      r_div  <= '0;
      r_q    <= '0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_cnt  <= CW'(STEPS);
      r_part <= {1'b0, dividend};
      r_div  <= divisor;
      r_q    <= '0;
    end else if (r_busy) begin
      r_q    <= {r_q[N+1:0], w_ge};
      r_part <= {w_rest, 1'b0};
      r_cnt  <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        r_busy <= 1'b0;
      end
    end
  end

  // done marks the final iteration; q and rem are complete from the next cycle.
  assign busy = r_busy;
  assign done = r_busy && (r_cnt == CW'(1));
  assign q    = r_q;
  assign rem  = r_part[N:1];

endmodule
`default_nettype wire

// File: rtl/fp_div_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : fp_div_gen                                                  |
// | Brief  : fixed-latency IEEE-style divider, RNE, DAZ/FTZ              |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module fp_div_gen
  import fp_pkg::*;
#(
  parameter int EW = 8,
  parameter int MW = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  input  logic [EW+MW:0]   opA,
  input  logic [EW+MW:0]   opB,
  output logic [EW+MW:0]   quotient,
  output logic             valid,
  output logic             invalid,
  output logic             dbz,
  output logic             overflow,
  output logic             underflow,
  output logic             inexact
);

  localparam int BIAS = 2**(EW-1) - 1;
  localparam logic [EW+MW:0] c_QNAN =
    (EW+MW+1)'({1'b0, {EW{1'b1}}, 1'b1}) << (MW - 1);

  function automatic cls_e classify(input logic [EW-1:0] e, input logic [MW-1:0] m);
    if (e == '0)      return ZERO;
    else if (e == '1) return (m == '0) ? INF : NAN;
    else              return NORMAL;
  endfunction

  state_e           r_state;
  logic [EW+MW:0]   r_a, r_b, r_quot;
  logic [MW:0]      r_sig;
  logic             r_g, r_s, r_valid;
  logic [EW+1:0]    r_e;
  flags_t           r_flags;

  logic             w_accept, w_div_busy, w_div_done, w_hi, w_sign, w_rup;
  logic [MW+3:0]    w_q;
  logic [MW:0]      w_rem, w_sig;
  logic             w_g, w_s, w_ovf, w_unf;
  logic [EW+1:0]    w_e_norm, w_e_rnd;
  logic [MW+1:0]    w_sum;
  logic [MW-1:0]    w_man;
  cls_e             w_ca, w_cb;
  logic [EW+MW:0]   w_res;
  flags_t           w_fl;

  assign w_accept = start && (r_state == IDLE);

  mant_div #(.N(MW+1)) u_mant_div (
    .clk      (clk),
    .reset    (reset),
    .start    (w_accept),
    .dividend ({1'b1, opA[MW-1:0]}),
    .divisor  ({1'b1, opB[MW-1:0]}),
    .busy     (w_div_busy),
    .done     (w_div_done),
    .q        (w_q),
    .rem      (w_rem)
  );

  assign w_hi     = w_q[MW+3];
  assign w_sig    = w_hi ? w_q[MW+3:3] : w_q[MW+2:2];
  assign w_g      = w_hi ? w_q[2] : w_q[1];
  assign w_s      = (w_hi ? |w_q[1:0] : w_q[0]) | (|w_rem);
  assign w_e_norm = {2'b00, r_a[EW+MW-1:MW]} - {2'b00, r_b[EW+MW-1:MW]}
                  + (EW+2)'(BIAS) - {{(EW+1){1'b0}}, ~w_hi};

  assign w_rup   = r_g & (r_s | r_sig[0]);
  assign w_sum   = {1'b0, r_sig} + {{(MW+1){1'b0}}, w_rup};
  assign w_e_rnd = r_e + {{(EW+1){1'b0}}, w_sum[MW+1]};
  assign w_man   = w_sum[MW+1] ? w_sum[MW:1] : w_sum[MW-1:0];
  assign w_ovf   = $signed(w_e_rnd) >= $signed((EW+2)'(2**EW - 1));
  assign w_unf   = $signed(w_e_rnd) <= $signed((EW+2)'(0));

  assign w_sign = r_a[EW+MW] ^ r_b[EW+MW];
  assign w_ca   = classify(r_a[EW+MW-1:MW], r_a[MW-1:0]);
  assign w_cb   = classify(r_b[EW+MW-1:MW], r_b[MW-1:0]);

  always_comb begin
    w_res = {w_sign, w_e_rnd[EW-1:0], w_man};
    w_fl  = '{invalid: 1'b0, dbz: 1'b0, overflow: 1'b0, underflow: 1'b0,
              inexact: r_g | r_s};
    if (w_ca == NAN || w_cb == NAN || (w_ca == ZERO && w_cb == ZERO) ||
        (w_ca == INF && w_cb == INF)) begin
      w_res = c_QNAN;
      w_fl  = '{invalid: 1'b1, default: 1'b0};
    end else if (w_ca == INF) begin
      w_res = {w_sign, {EW{1'b1}}, {MW{1'b0}}};
      w_fl  = '0;
    end else if (w_cb == ZERO) begin
      w_res = {w_sign, {EW{1'b1}}, {MW{1'b0}}};
      w_fl  = '{dbz: 1'b1, default: 1'b0};
    end else if (w_ca == ZERO || w_cb == INF) begin
      w_res = {w_sign, {(EW+MW){1'b0}}};
      w_fl  = '0;
    end else if (w_ovf) begin
      w_res = {w_sign, {EW{1'b1}}, {MW{1'b0}}};
      w_fl  = '{overflow: 1'b1, inexact: 1'b1, default: 1'b0};
    end else if (w_unf) begin
      w_res = {w_sign, {(EW+MW){1'b0}}};
      w_fl  = '{underflow: 1'b1, inexact: 1'b1, default: 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sig   <= '0;
      r_g     <= 1'b0;
      r_s     <= 1'b0;
      r_e     <= '0;
      r_quot  <= '0;
      r_flags <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_a     <= opA;
          r_b     <= opB;
          r_state <= DIV;
        end
        // An idle divider here would otherwise strand the FSM in DIV.
        DIV: if (w_div_done || !w_div_busy) r_state <= NORM;
        NORM: begin
          r_sig   <= w_sig;
          r_g     <= w_g;
          r_s     <= w_s;
          r_e     <= w_e_norm;
          r_state <= ROUND;
        end
        ROUND: begin
          r_quot  <= w_res;
          r_flags <= w_fl;
          r_valid <= 1'b1;
          r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready     = (r_state == IDLE);
  assign valid     = r_valid;
  assign quotient  = r_quot;
  assign invalid   = r_flags.invalid;
  assign dbz       = r_flags.dbz;
  assign overflow  = r_flags.overflow;
  assign underflow = r_flags.underflow;
  assign inexact   = r_flags.inexact;

endmodule
`default_nettype wire

// File: doc/fp_div_gen.md
FP_DIV_GEN -- requirements
Module: fp_div_gen

Interface
REQ-001 SHALL have parameter EW, default 8, exponent width.
REQ-002 SHALL have parameter MW, default 7, stored mantissa width; W = 1+EW+MW, BIAS = 2^(EW-1)-1.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  request; accepted only in a cycle where ready=1.
REQ-006 ready  out  1  high in IDLE only.
REQ-007 opA, opB  in  W each  dividend, divisor; {sign, exp, mant}; sampled on acceptance.
REQ-008 quotient  out  W  result; held until next valid.
REQ-009 valid  out  1  one-cycle pulse, quotient and flags are valid.
REQ-010 invalid, dbz, overflow, underflow, inexact  out  1 each  IEEE-style flags; updated with valid, held otherwise.

Function
REQ-011 SHALL use FSM IDLE -> DIV -> NORM -> ROUND -> DONE -> IDLE; DONE lasts exactly one cycle and asserts valid.
REQ-012 Acceptance in cycle t SHALL produce valid in cycle t+MW+7 for every operand class, specials included (fixed latency).
REQ-013 start while ready=0 SHALL be ignored; operands are registered at acceptance, so later input changes have no effect.
REQ-014 DIV SHALL run MW+4 cycles, producing one bit per cycle by restoring division: Q = floor(2^(MW+3) * {1,mA} / {1,mB}), width MW+4, plus remainder.
REQ-015 NORM: if Q[MW+3]=1, significand = Q[MW+3:3], guard = Q[2], sticky = |Q[1:0] or rem!=0, exponent adj 0; else significand = Q[MW+2:2], guard = Q[1], sticky = Q[0] or rem!=0, adj -1.
REQ-016 Biased exponent SHALL be computed signed in EW+2 bits: E = eA - eB + BIAS + adj.
REQ-017 ROUND SHALL apply round-to-nearest-even; a carry out of the mantissa SHALL increment E.
REQ-018 inexact = guard | sticky for finite results.
REQ-019 E >= 2^EW-1 after rounding: quotient = signed infinity, overflow=1, inexact=1.
REQ-020 E <= 0: quotient = signed zero (flush, no subnormal output), underflow=1, inexact=1.
REQ-021 Subnormal inputs (exp=0) SHALL be treated as signed zero (DAZ).
REQ-022 NaN operand, 0/0, or inf/inf: quotient = canonical qNaN (sign 0, exp all ones, mant MSB 1, rest 0), invalid=1, all other flags 0.
REQ-023 finite nonzero / 0: signed infinity, dbz=1; inf / finite: signed infinity, no flags; 0 / nonzero or finite / inf: signed zero, no flags.
REQ-024 Result sign SHALL be sA xor sB, except NaN.
REQ-025 Each valid SHALL overwrite all five flags (non-sticky across operations).

Reset
REQ-026 reset SHALL force IDLE, ready=1 in the following cycle, valid=0, quotient=0, all flags 0.
REQ-027 reset during DIV/NORM/ROUND/DONE SHALL abort the operation; no valid for it is ever produced.
REQ-028 reset SHALL take priority over a simultaneous start.

Structure
REQ-029 Shared package fp_pkg SHALL hold the FSM state enum, the operand-class enum (ZERO, NORMAL, INF, NAN) and the flag-bundle struct.
REQ-030 Iterative mantissa divider SHALL be a sub-module mant_div (parameter N=MW+1; start, busy, done, q, rem); classification, exponent, normalise, round stay in fp_div_gen.

Verification (EW=8, MW=7)
REQ-031 0x3F80 / 0x4040 (1/3) -> 0x3EAB, inexact=1, other flags 0, valid exactly 14 cycles after acceptance.
REQ-032 0x40C0 / 0x4000 (6/2) -> 0x4040, all flags 0; a second start issued during DIV is ignored.
REQ-033 0x3F80 / 0x0000 -> 0x7F80, dbz=1; 0x0000 / 0x0000 -> 0x7FC0, invalid=1.
REQ-034 0x7F00 / 0x3F00 -> 0x7F80, overflow=1, inexact=1; 0x0080 / 0x4000 -> 0x0000, underflow=1, inexact=1.
REQ-035 reset asserted 3 cycles after acceptance -> no valid; ready=1 next cycle; outputs 0; then 0xC000 / 0x4000 -> 0xBF80, no flags.
